// File: rtl/autosym_pkg.sv
// Shared encodings and helpers for the autosymmetric function evaluator.
package autosym_pkg;

  typedef enum logic [1:0] {
    SEL_ROW = 2'b00,
    SEL_TAB = 2'b01,
    SEL_POL = 2'b10,
    SEL_RSV = 2'b11
  } cfg_sel_e;

  typedef enum logic [1:0] {
    CONFIG = 2'b00,
    RUN    = 2'b01,
    DRAIN  = 2'b10
  } state_e;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/autosym_eval_pipe_if.sv
// Configuration, input-stream and output-stream signals of the evaluator.
interface autosym_eval_pipe_if
  import autosym_pkg::*;
#(
  parameter int N_IN  = 7,
  parameter int N_OUT = 1,
  parameter int N_RED = 4
);
  localparam int DATA_W = max_int(N_IN, N_OUT);
  localparam int ADDR_W = N_RED;

  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_commit;
  logic              cfg_unlock;
  logic              cfg_err;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_data;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_wdata, cfg_commit, cfg_unlock,
    output in_valid, in_data, out_ready,
    input  cfg_err, busy, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_wdata, cfg_commit, cfg_unlock,
    input  in_valid, in_data, out_ready,
    output cfg_err, busy, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/autosym_proj.sv
// Combinational GF(2) matrix-vector product: o_r[i] = parity(i_x & i_a[i]).
module autosym_proj #(
  parameter int N_IN  = 7,
  parameter int N_RED = 4
) (
  input  logic [N_IN-1:0]             i_x,
  input  logic [N_RED-1:0][N_IN-1:0]  i_a,
  output logic [N_RED-1:0]            o_r
);

  // one parity tree per matrix row
  always_comb begin
    o_r = '0;
    for (int i = 0; i < N_RED; i++) begin
      o_r[i] = ^(i_x & i_a[i]);
    end
  end

endmodule

// File: rtl/autosym_eval_pipe.sv
// Programmable f(x) = g(A*x) evaluator with a two-stage valid/ready pipeline
// and a CONFIG/RUN/DRAIN controller guarding run-time reconfiguration.
module autosym_eval_pipe
  import autosym_pkg::*;
#(
  parameter int N_IN  = 7,
  parameter int N_OUT = 1,
  parameter int N_RED = 4
) (
  input logic                clk,
  input logic                rst_n,
  autosym_eval_pipe_if.slave bus
);

  localparam int ADDR_W = N_RED;
  localparam int TAB_D  = 1 << N_RED;
  localparam logic [ADDR_W:0] ROW_LIM = (ADDR_W + 1)'(N_RED);

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [N_RED-1:0][N_IN-1:0] r_a;
  logic [N_OUT-1:0]          r_tab [TAB_D];
  logic [N_OUT-1:0]          r_pol;
  logic [N_OUT-1:0]          r_out_data;
  logic [ADDR_W-1:0]         r_s1_r;
  logic [ADDR_W-1:0]         w_proj;
  logic                      r_s1_v, r_s2_v, r_cfg_err, r_busy;
  logic                      w_s1_adv, w_s2_adv, w_in_ready, w_accept;
  logic                      w_row_oob, w_wr_ok, w_wr_bad, w_commit_ok;
  logic                      w_unused;

  assign w_s2_adv    = !r_s2_v || bus.out_ready;
  assign w_s1_adv    = !r_s1_v || w_s2_adv;
  assign w_in_ready  = (r_state == RUN) && w_s1_adv;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_row_oob   = {1'b0, bus.cfg_addr} >= ROW_LIM;
  assign w_commit_ok = (r_state == CONFIG) && bus.cfg_commit;
  assign w_unused    = ^bus.cfg_wdata;

  autosym_proj #(.N_IN(N_IN), .N_RED(N_RED)) u_proj (
    .i_x (bus.in_data),
    .i_a (r_a),
    .o_r (w_proj)
  );

  // classify a config write as applied or dropped-with-error
  always_comb begin
    w_wr_ok  = 1'b0;
    w_wr_bad = 1'b0;
    if (bus.cfg_we) begin
      if ((r_state == CONFIG) && (bus.cfg_sel != SEL_RSV) &&
          !((bus.cfg_sel == SEL_ROW) && w_row_oob)) begin
        w_wr_ok = 1'b1;
      end else begin
        w_wr_bad = 1'b1;
      end
    end else begin
      w_wr_ok  = 1'b0;
      w_wr_bad = 1'b0;
    end
  end

  // controller next state; a same-cycle write still lands before RUN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CONFIG: begin
        if (bus.cfg_commit) w_state_nxt = RUN;
        else                w_state_nxt = CONFIG;
      end
      RUN: begin
        if (bus.cfg_unlock) w_state_nxt = DRAIN;
        else                w_state_nxt = RUN;
      end
      DRAIN: begin
        if (!r_s1_v && !r_s2_v) w_state_nxt = CONFIG;
        else                    w_state_nxt = DRAIN;
      end
      default: w_state_nxt = CONFIG;
    endcase
  end

  // controller state and registered busy flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CONFIG;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != CONFIG);
    end
  end

  // matrix rows, restriction table and polarity mask
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_pol <= '0;
      for (int k = 0; k < TAB_D; k++) begin
        r_tab[k] <= '0;
      end
    end else if (w_wr_ok) begin
      case (cfg_sel_e'(bus.cfg_sel))
        SEL_ROW: begin
          for (int i = 0; i < N_RED; i++) begin
            if (bus.cfg_addr == ADDR_W'(i)) r_a[i] <= bus.cfg_wdata[N_IN-1:0];
          end
        end
        SEL_TAB: r_tab[bus.cfg_addr] <= bus.cfg_wdata[N_OUT-1:0];
        SEL_POL: r_pol <= bus.cfg_wdata[N_OUT-1:0];
        default: r_pol <= r_pol;
      endcase
    end
  end

  // sticky error: a bad write wins over a clearing commit in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
    end else if (w_wr_bad) begin
      r_cfg_err <= 1'b1;
    end else if (w_commit_ok) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= r_cfg_err;
    end
  end

  // stage 1 holds the reduced index, stage 2 the looked-up result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_r     <= '0;
      r_s2_v     <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_v <= w_accept;
        if (w_accept) r_s1_r <= w_proj;
      end
      if (w_s2_adv) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) r_out_data <= r_tab[r_s1_r] ^ r_pol;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_v;
  assign bus.out_data  = r_out_data;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.busy      = r_busy;

endmodule

// File: doc/autosym_eval_pipe.md
Name: autosym_eval_pipe

Overview:
- Parametrised, programmable evaluator for autosymmetric Boolean functions of the kind used in our benchmark set: f(x) = g(A·x).
  - A is an N_RED x N_IN binary compression matrix over GF(2).
  - g is a stored restriction table with 2^N_RED entries of N_OUT bits.
- Generalises the fixed 7-in/1-out optimised netlists to any width and output count, with run-time reconfiguration.
- Adds a 2-stage valid/ready pipeline so it can sit in a streaming test harness between a vector source and a checker.

Parameters:
- N_IN, 7, number of primary inputs.
- N_OUT, 1, number of outputs.
- N_RED, 4, reduced dimension (rows of A); table depth 2^N_RED; 1 <= N_RED <= N_IN.
- Derived localparam DATA_W = max(N_IN, N_OUT).
- Derived localparam ADDR_W = N_RED.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  configuration write strobe
- cfg_sel  in  2  target: 00 matrix row, 01 table entry, 10 output polarity mask, 11 reserved
- cfg_addr  in  ADDR_W  row index (00) or table index (01); ignored for 10
- cfg_wdata  in  DATA_W  row uses [N_IN-1:0]; table and mask use [N_OUT-1:0]
- cfg_commit  in  1  leave CONFIG, enter RUN
- cfg_unlock  in  1  request return to CONFIG
- cfg_err  out  1  sticky illegal-config-access flag
- busy  out  1  state != CONFIG
- in_valid  in  1  input vector valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_data  in  N_IN  input vector x
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  N_OUT  f(x)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
  - Clock port is clk, reset port is rst_n.
  - All state updates occur on posedge clk.
- Reset (rst_n=0 at an edge), including mid-operation:
  - State goes to CONFIG.
  - All A rows, all table entries and the polarity mask go to 0.
  - Both stage valids go to 0; out_data=0, out_valid=0, cfg_err=0, in_ready=0, busy=0.
  - In-flight vectors are discarded.
- States:
  - CONFIG: config writes legal, in_ready=0. cfg_commit goes to RUN next cycle; cfg_we takes precedence in the same cycle, so the write lands and then RUN is entered.
  - RUN: in_ready per pipeline rule. cfg_unlock goes to DRAIN; cfg_commit is ignored.
  - DRAIN: in_ready=0; stages keep flowing. When both stage valids are 0 (and no stage loads this cycle), go to CONFIG next cycle.
- Config writes:
  - cfg_we in RUN or DRAIN: the write is dropped and cfg_err is set.
  - cfg_sel=11 in any state: the write is dropped and cfg_err is set.
  - cfg_addr >= N_RED with sel=00: the write is dropped and cfg_err is set.
  - cfg_err clears only on reset or on an accepted cfg_commit.
- Datapath:
  - Stage 1 registers r, where r[i] = XOR-reduce(in_data & A[i]).
  - Stage 2 registers out_data = table[r] XOR polarity mask.
  - Latency: 2 cycles from accept to out_valid when no backpressure. Throughput is 1 vector/cycle.
- Handshake:
  - s2_adv = !s2_v || out_ready.
  - s1_adv = !s1_v || s2_adv.
  - in_ready = (state==RUN) && s1_adv, combinational from out_ready.
  - out_data is held stable while out_valid && !out_ready.
  - No vector is lost or duplicated under arbitrary out_ready patterns.
- Simultaneous events: cfg_unlock together with an in_valid handshake in the same RUN cycle — the vector is accepted and drains normally.
- Config in CONFIG does not affect outputs already delivered. The pipeline is always empty in CONFIG, so no mid-stream table change is possible.

Decomposition:
- Package autosym_pkg holds:
  - The cfg_sel encodings: SEL_ROW, SEL_TAB, SEL_POL, SEL_RSV.
  - The state enum: CONFIG, RUN, DRAIN.
  - A function for the DATA_W max.
- One natural sub-module: autosym_proj, a purely combinational GF(2) matrix-vector product (N_IN -> N_RED). It is reused by the checker model.

Test Plan:
- Configuration: N_IN=7, N_RED=4, N_OUT=1.
  - A rows = one-hot x0..x3.
  - Table[k] = parity(k).
  - Mask=0, then commit.
  - Stimulus: in_data=7'b0000111 with out_ready=1. Required response: out_data=1, out_valid exactly 2 cycles after accept.
  - Stimulus: in_data=7'b0001111. Required response: out_data=0.
- Same config, mask=1: in_data=7'b0000111 -> out_data=0 (inverted output).
- Backpressure:
  - Stimulus: stream 8 vectors, out_ready toggling 1,0,0,1,…
  - Required response: exactly 8 outputs, in order, matching the model. out_data stable while stalled. in_ready=0 whenever both stages are full and out_ready=0.
- Illegal access:
  - cfg_we in RUN -> cfg_err=1, and the table is unchanged (verified by the next output).
  - cfg_sel=11 in CONFIG -> cfg_err=1.
  - cfg_commit -> cfg_err=0.
- Drain:
  - Stimulus: cfg_unlock with 2 vectors in flight and out_ready=0 for 3 cycles.
  - Required response: busy=1 and in_ready=0 until both outputs are delivered; CONFIG is entered the cycle after the last out handshake.
- Reset mid-stream: assert rst_n=0 with s1_v=s2_v=1 -> next cycle out_valid=0, busy=0, and all table reads return 0 after re-commit without writes.
